rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters: core writeback (port 0) and host/debug loader (port 1).
- Uses valid/ready handshakes and round-robin arbitration.
- Includes a clear sequencer that walks every register address writing zero, used after program load or on a debug command.
- Outputs drive the register file's write-enable, write-address and write-data inputs directly.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- DEPTH, 32, number of registers swept by the clear sequence; must be ≤ 2^ADDR_W.

Ports:
- inclk  in  1  clock; all state changes on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  port 0 (core) write request.
- req0_addr  in  ADDR_W  port 0 target register.
- req0_data  in  DATA_W  port 0 write data.
- req0_ready  out  1  port 0 request accepted this cycle.
- req1_valid  in  1  port 1 (host) write request.
- req1_addr  in  ADDR_W  port 1 target register.
- req1_data  in  DATA_W  port 1 write data.
- req1_ready  out  1  port 1 request accepted this cycle.
- clear_start  in  1  single-cycle pulse; begins the clear sweep.
- clear_busy  out  1  high while the clear sweep is running.
- clear_done  out  1  one-cycle pulse after the last clear write is issued.
- RF_W  out  1  register-file write enable, registered.
- write_addr  out  ADDR_W  register-file write address, registered.
- write_data  out  DATA_W  register-file write data, registered.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, rr_ptr=0, clear counter=0. RF_W, write_addr, write_data, clear_busy and clear_done all 0. Readies are forced to 0 while rstn is low.
- States: IDLE, CLEAR.
- Transfer rule: a transfer occurs when reqN_valid && reqN_ready at a rising edge.
- Readiness: readies are combinational from the valids, state and rr_ptr. At most one ready is high per cycle, and readies are 0 in CLEAR.
- IDLE arbitration:
  - Only one valid: that port is ready.
  - Both valid: the port selected by rr_ptr is ready.
  - After a grant to port k, rr_ptr is set to the other port. rr_ptr is unchanged when there is no grant.
- Write latency: a transfer accepted at edge N drives RF_W=1 with the captured addr/data during cycle N+1. The register file commits at edge N+1.
- RF_W with no transfer: RF_W is 0 in any cycle that follows an edge with no transfer and no clear write. write_addr and write_data hold their last values.
- Back-to-back operation: one write per cycle is sustainable, including alternating ports when both are continuously valid (strict alternation).
- Valid rules: a requester must hold valid and its payload stable until ready. Deasserting valid without ready is allowed and causes no write.
- Entering CLEAR: clear_start sampled high in IDLE moves the block to CLEAR and sets the counter to 0. clear_start has priority over any same-cycle request: no ready is asserted in that cycle.
- CLEAR sweep:
  - Each cycle in CLEAR registers RF_W=1, write_addr=counter, write_data=0, then increments the counter.
  - When the write for counter=DEPTH-1 is registered, the block returns to IDLE and pulses clear_done for the cycle in which that final write is presented.
  - The sweep produces DEPTH consecutive RF_W cycles.
- clear_busy: 1 in every cycle while state=CLEAR.
- clear_start while CLEAR: ignored; the sweep does not restart.
- Pending requests during CLEAR are stalled (ready=0), not dropped. Arbitration resumes in the first IDLE cycle using the preserved rr_ptr.
- Reset mid-sweep: aborts immediately to the reset values. Partially cleared registers stay as written.
- Address/data widths: passed through unmodified, with no wrap. The counter is ADDR_W+1 bits wide, so DEPTH=2^ADDR_W terminates correctly.

Optional Feature:
- Macro: RF_X0_GUARD_EN.
- When defined:
  - A transfer with addr==0 still completes its handshake (ready behaves normally) and still advances rr_ptr.
  - RF_W stays 0 for that write, so register 0 is never written by requesters.
  - The clear sweep starts at address 1 and issues DEPTH-1 writes.
- When undefined: address 0 is treated like any other address, and the sweep covers 0..DEPTH-1.

Test Plan:
- Reset: hold rstn low mid-run, then release → RF_W=0, both readies 0 during reset, rr_ptr=0. The first simultaneous request grants port 0.
- Single port: req0 addr=5, data=0xDEADBEEF valid for 1 cycle → req0_ready=1 that cycle; next cycle RF_W=1, write_addr=5, write_data=0xDEADBEEF; the cycle after, RF_W=0.
- Contention: both valid for 4 cycles (port0 addr=1, port1 addr=2) → grants 0,1,0,1; RF_W high 4 consecutive cycles, write_addr 1,2,1,2.
- Clear with collision: clear_start together with req1_valid (addr=7) → req1_ready=0. clear_busy is high for 32 cycles, with write_addr 0..31 and data 0. clear_done pulses with the addr=31 write. req1 is granted in the first IDLE cycle, and its write (addr=7) follows the sweep.
- Restart ignored: clear_start re-pulsed at sweep cycle 10 → sweep still ends after 32 writes, with exactly one clear_done.
- RF_X0_GUARD_EN defined: req0 addr=0, data=0x1234 → req0_ready=1, RF_W stays 0. The clear sweep issues 31 writes with addresses 1..31.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the single register-file write port.
// Core writeback (port 0) and host/debug loader (port 1) share the port
// through valid/ready handshakes with round-robin arbitration. A clear
// sequencer can sweep every register, writing zero.
// Optional build macro RF_X0_GUARD_EN: register 0 is never written by
// requesters, and the clear sweep starts at address 1.

module rf_write_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              inclk,
    input  logic              rstn,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              RF_W,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // The counter is one bit wider than the address so DEPTH == 2^ADDR_W
    // can still be reached and compared without wrapping.
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
`ifdef RF_X0_GUARD_EN
    localparam logic [ADDR_W:0] CNT_FIRST = (ADDR_W+1)'(1);
`else
    localparam logic [ADDR_W:0] CNT_FIRST = '0;
`endif

    state_t          state;
    state_t          next_state;
    logic            rr_ptr;
    logic [ADDR_W:0] clr_cnt;
    logic            grant0;
    logic            grant1;
    logic            sweep_last;
    logic            wr_ok0;
    logic            wr_ok1;

    // >= rather than == keeps the sweep terminating even for degenerate DEPTH.
    assign sweep_last = (clr_cnt >= CNT_LAST);
    assign clear_busy = (state == CLEAR);
    assign req0_ready = grant0;
    assign req1_ready = grant1;

`ifdef RF_X0_GUARD_EN
    assign wr_ok0 = (req0_addr != '0);
    assign wr_ok1 = (req1_addr != '0);
`else
    assign wr_ok0 = 1'b1;
    assign wr_ok1 = 1'b1;
`endif

    // Next-state and ready generation; clear_start beats any same-cycle request.
    always_comb begin
        next_state = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    next_state = CLEAR;
                end else if (req0_valid && req1_valid) begin
                    grant0 = ~rr_ptr;
                    grant1 = rr_ptr;
                end else begin
                    grant0 = req0_valid;
                    grant1 = req1_valid;
                end
            end
            CLEAR: begin
                if (sweep_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (!rstn) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge inclk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Round-robin pointer points at the port that did not win last time;
    // sweep counter loads on entry to CLEAR and advances once per sweep cycle.
    always_ff @(posedge inclk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr  <= 1'b0;
            clr_cnt <= '0;
        end else begin
            if (grant0) begin
                rr_ptr <= 1'b1;
            end else if (grant1) begin
                rr_ptr <= 1'b0;
            end
            if (state == IDLE && clear_start) begin
                clr_cnt <= CNT_FIRST;
            end else if (state == CLEAR) begin
                clr_cnt <= clr_cnt + CNT_ONE;
            end
        end
    end

    // Registered write port: a sweep write or the accepted request, else idle.
    always_ff @(posedge inclk or negedge rstn) begin
        if (!rstn) begin
            RF_W       <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            clear_done <= 1'b0;
        end else begin
            RF_W       <= 1'b0;
            clear_done <= 1'b0;
            if (state == CLEAR) begin
                RF_W       <= 1'b1;
                write_addr <= clr_cnt[ADDR_W-1:0];
                write_data <= '0;
                clear_done <= sweep_last;
            end else if (grant0) begin
                if (wr_ok0) begin
                    RF_W       <= 1'b1;
                    write_addr <= req0_addr;
                    write_data <= req0_data;
                end
            end else if (grant1) begin
                if (wr_ok1) begin
                    RF_W       <= 1'b1;
                    write_addr <= req1_addr;
                    write_data <= req1_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: scoreboard bench for rf_write_arbiter.
// A reference model predicts readies and the stream of register-file
// writes (with the cycle each should appear); a monitor pops and compares.

module tb_rf_write_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
`ifdef RF_X0_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                done;
    } exp_t;

    logic              inclk = 1'b0;
    logic              rstn = 1'b0;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req1_ready;
    logic              clear_start = 1'b0;
    logic              clear_busy;
    logic              clear_done;
    logic              RF_W;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   m_clear_left = 0;
    bit   m_prefer = 1'b0;
    bit   acc0 = 1'b0;
    bit   acc1 = 1'b0;

    rf_write_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .inclk      (inclk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .clear_start(clear_start),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .RF_W       (RF_W),
        .write_addr (write_addr),
        .write_data (write_data)
    );

    // Free-running clock and cycle counter.
    always #5 inclk = ~inclk;

    always @(posedge inclk) cyc <= cyc + 1;

    // One comparison: count it, report on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Monitor plus reference model, evaluated away from the active edge.
    always @(negedge inclk) begin
        exp_t e;
        bit   exp_r0;
        bit   exp_r1;
        int   n;
        int   first;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!rstn) begin
            checkOutput("reset_rf_w", RF_W, 0);
            checkOutput("reset_ready0", req0_ready, 0);
            checkOutput("reset_ready1", req1_ready, 0);
            checkOutput("reset_busy", clear_busy, 0);
            checkOutput("reset_done", clear_done, 0);
            exp_q.delete();
            m_clear_left = 0;
            m_prefer = 1'b0;
        end else begin
            if (RF_W) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write cycle=%0d actual addr=%0h required none", cyc, write_addr);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("write_cycle", cyc, e.cyc);
                    checkOutput("write_addr", write_addr, e.addr);
                    checkOutput("write_data", write_data, e.data);
                    checkOutput("clear_done", clear_done, e.done);
                end
            end else begin
                checkOutput("spurious_done", clear_done, 0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    total++;
                    bad++;
                    $display("[TB] FAIL missing_write cycle=%0d actual RF_W=0 required addr=%0h", cyc, e.addr);
                end
            end
            checkOutput("clear_busy", clear_busy, (m_clear_left > 0) ? 1 : 0);

            exp_r0 = 1'b0;
            exp_r1 = 1'b0;
            if (m_clear_left > 0) begin
                m_clear_left--;
            end else if (clear_start) begin
                n     = GUARD ? DEPTH - 1 : DEPTH;
                first = GUARD ? 1 : 0;
                for (int i = 0; i < n; i++) begin
                    e.cyc  = cyc + 2 + i;
                    e.addr = ADDR_W'(first + i);
                    e.data = '0;
                    e.done = (i == n - 1);
                    exp_q.push_back(e);
                end
                m_clear_left = n;
            end else begin
                if (req0_valid && req1_valid) begin
                    exp_r0 = (m_prefer == 1'b0);
                    exp_r1 = (m_prefer == 1'b1);
                end else begin
                    exp_r0 = req0_valid;
                    exp_r1 = req1_valid;
                end
                if (exp_r0) begin
                    m_prefer = 1'b1;
                    if (!(GUARD && req0_addr == '0)) begin
                        e.cyc = cyc + 1; e.addr = req0_addr; e.data = req0_data; e.done = 1'b0;
                        exp_q.push_back(e);
                    end
                end else if (exp_r1) begin
                    m_prefer = 1'b0;
                    if (!(GUARD && req1_addr == '0)) begin
                        e.cyc = cyc + 1; e.addr = req1_addr; e.data = req1_data; e.done = 1'b0;
                        exp_q.push_back(e);
                    end
                end
            end
            checkOutput("ready0", req0_ready, exp_r0);
            checkOutput("ready1", req1_ready, exp_r1);
            acc0 = exp_r0;
            acc1 = exp_r1;
        end
    end

    // Advance one cycle; inputs change just after the rising edge.
    task automatic tick();
        @(posedge inclk);
        #1;
    endtask

    // Drive a full set of request/clear inputs and hold them for one cycle.
    task automatic applyStimulus(input bit v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                                 input bit v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                                 input bit cs);
        req0_valid  = v0;
        req0_addr   = a0;
        req0_data   = d0;
        req1_valid  = v1;
        req1_addr   = a1;
        req1_data   = d1;
        clear_start = cs;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, '0, '0, 0);
    endtask

    // Wait for the modelled sweep to finish, bounded.
    task automatic waitSweep();
        int t;
        t = 0;
        while (m_clear_left > 0 && t < 200) begin
            tick();
            t++;
        end
        if (m_clear_left > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL sweep_timeout actual still_busy required idle");
        end
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        int t;
        // Reset held for a few cycles, then first simultaneous request.
        idle(3);
        rstn = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 5'd1, 32'hA0A0_0001, 1, 5'd2, 32'hB0B0_0002, 0);
        idle(2);

        // Single port write.
        applyStimulus(1, 5'd5, 32'hDEAD_BEEF, 0, '0, '0, 0);
        idle(3);

        // Address 0 from a requester.
        applyStimulus(1, 5'd0, 32'h0000_1234, 0, '0, '0, 0);
        idle(2);

        // Clear colliding with a port 1 request that must stall, not drop.
        applyStimulus(0, '0, '0, 1, 5'd7, 32'h7777_0007, 1);
        clear_start = 1'b0;
        t = 0;
        while (!acc1 && t < 100) begin
            tick();
            t++;
        end
        if (!acc1) begin
            total++;
            bad++;
            $display("[TB] FAIL stalled_req_timeout actual not_granted required granted");
        end
        idle(3);

        // Re-pulsed clear_start mid-sweep is ignored.
        applyStimulus(0, '0, '0, 0, '0, '0, 1);
        idle(9);
        applyStimulus(0, '0, '0, 0, '0, '0, 1);
        idle(1);
        waitSweep();
        idle(3);

        // Reset in the middle of a sweep, then arbitration restarts at port 0.
        applyStimulus(0, '0, '0, 0, '0, '0, 1);
        idle(5);
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(1);
        applyStimulus(1, 5'd9, 32'h1111_2222, 1, 5'd10, 32'h3333_4444, 0);
        applyStimulus(0, '0, '0, 1, 5'd10, 32'h3333_4444, 0);
        idle(2);

        // Randomized traffic: hold valid until accepted, occasional drops and clears.
        for (int k = 0; k < 500; k++) begin
            if (acc0 || (req0_valid && $urandom_range(0, 9) == 0)) req0_valid = 1'b0;
            if (acc1 || (req1_valid && $urandom_range(0, 9) == 0)) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 2) != 0) begin
                req0_valid = 1'b1;
                req0_addr  = ADDR_W'($urandom);
                req0_data  = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 2) != 0) begin
                req1_valid = 1'b1;
                req1_addr  = ADDR_W'($urandom);
                req1_data  = $urandom;
            end
            clear_start = ($urandom_range(0, 59) == 0);
            tick();
        end

        idle(80);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
